// File: rtl/enc_neuron_seq.sv
// ============================================================================
// enc_neuron_seq
// ----------------------------------------------------------------------------
// Purpose:
//   Sequential neuron controller for the FI-GAN encoder layers. A single
//   signed multiply-accumulate unit is time-multiplexed across the N_IN
//   weights of one neuron. Weights come from an external combinational
//   weight ROM addressed by w_addr. Input activations stream in over a
//   valid/ready handshake. After the last input the bias is added, the sum is
//   rescaled from the product fixed-point format back to the activation
//   format, saturated to DATA_WIDTH, passed through the activation function
//   and presented over an output valid/ready handshake.
//
// Configuration macro:
//   ENC_LEAKY_RELU_EN  - when defined, the activation is leaky ReLU with a
//                        slope of 1/8 (negative r becomes r >>> 3).
//                        When undefined, plain ReLU (negative r becomes 0).
//
// Parameters:
//   DATA_WIDTH - width of activations, weights and bias (signed fixed point)
//   FRAC_BITS  - fractional bits of activations, weights and bias
//   N_IN       - inputs per neuron, a power of two >= 2
//
// Ports:
//   clk      in   clock, all logic on the rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin one neuron evaluation (honored only in IDLE)
//   busy     out  high in every state except IDLE
//   x_valid  in   input activation valid
//   x_ready  out  high only while accumulating
//   x_data   in   signed input activation
//   w_addr   out  weight index, equal to the current beat count
//   w_data   in   signed weight selected by w_addr (combinational source)
//   bias     in   signed neuron bias, sampled in the BIAS state
//   y_valid  out  output activation valid
//   y_ready  in   downstream accepts y_data
//   y_data   out  signed output activation
// ============================================================================
module enc_neuron_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int N_IN       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [DATA_WIDTH-1:0]         x_data,
    output logic [$clog2(N_IN)-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0]         w_data,
    input  logic [DATA_WIDTH-1:0]         bias,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [DATA_WIDTH-1:0]         y_data
);

    localparam int IDX_W  = $clog2(N_IN);
    localparam int PROD_W = 2 * DATA_WIDTH;
    // Wide enough to hold N_IN full-width products plus a shifted bias
    // without ever wrapping, so saturation only has to happen once at the end.
    localparam int ACC_W  = 2 * DATA_WIDTH + IDX_W + 1;

    // Representable output range expressed at accumulator width so the
    // saturation compare is a plain signed comparison.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        BIAS,
        ACT,
        OUT
    } state_t;

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_busy;
    logic                     r_xReady;
    logic                     r_yValid;
    logic [DATA_WIDTH-1:0]    r_yData;

    logic signed [PROD_W-1:0]     w_product;
    logic signed [ACC_W-1:0]      w_productExt;
    logic signed [ACC_W-1:0]      w_biasExt;
    logic signed [ACC_W-1:0]      w_shifted;
    logic signed [DATA_WIDTH-1:0] w_sat;
    logic signed [DATA_WIDTH-1:0] w_act;

    // Full-precision signed product of the current activation and weight,
    // sign-extended to the accumulator width.
    assign w_product    = $signed(x_data) * $signed(w_data);
    assign w_productExt = {{(ACC_W-PROD_W){w_product[PROD_W-1]}}, w_product};

    // The bias is in activation format; shifting it left by FRAC_BITS puts it
    // in the same binary-point position as the products.
    assign w_biasExt = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;

    // Rescale back to activation format (arithmetic shift, rounds toward
    // minus infinity) and clamp into the DATA_WIDTH signed range.
    assign w_shifted = r_acc >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = OUT_MAX;
        end else if (w_shifted < SAT_MIN) begin
            w_sat = OUT_MIN;
        end
    end

    // Activation on the saturated value. The leaky variant keeps a 1/8 slope
    // for negative inputs; the default variant clamps negatives to zero.
`ifdef ENC_LEAKY_RELU_EN
    assign w_act = w_sat[DATA_WIDTH-1] ? (w_sat >>> 3) : w_sat;
`else
    assign w_act = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`endif

    // Main controller. State, datapath registers and the handshake outputs
    // all live in this one block so every output is a flop and changes in
    // lockstep with the state it belongs to. Reset wins over everything and
    // simply drops any partially accumulated sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_xReady <= 1'b0;
            r_yValid <= 1'b0;
            r_yData  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_acc <= '0;
                    r_idx <= '0;
                    if (start) begin
                        r_state  <= ACC;
                        r_busy   <= 1'b1;
                        r_xReady <= 1'b1;
                    end
                end

                ACC: begin
                    if (x_valid) begin
                        r_acc <= r_acc + w_productExt;
                        // N_IN is a power of two, so the increment wraps the
                        // index back to zero on the final beat by itself.
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(N_IN - 1)) begin
                            r_state  <= BIAS;
                            r_xReady <= 1'b0;
                        end
                    end
                end

                BIAS: begin
                    r_acc   <= r_acc + w_biasExt;
                    r_state <= ACT;
                end

                ACT: begin
                    r_yData  <= w_act;
                    r_yValid <= 1'b1;
                    r_state  <= OUT;
                end

                OUT: begin
                    // Start is not looked at here; a new evaluation has to be
                    // requested from IDLE.
                    if (y_ready) begin
                        r_yValid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_xReady <= 1'b0;
                    r_yValid <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign x_ready = r_xReady;
    assign y_valid = r_yValid;
    assign y_data  = r_yData;
    assign w_addr  = r_idx;

endmodule

// File: tb/tb_enc_neuron_seq.sv
// ============================================================================
// tb_enc_neuron_seq
// ----------------------------------------------------------------------------
// Self-checking bench for enc_neuron_seq. A table of uniform-input vectors
// with hand-computed results drives the main runs; expected results go into
// a scoreboard queue when a run starts and are popped at the output
// handshake. A reset-mid-run sequence and a few random vectors (checked
// against a small reference model) cover the remaining corners.
// ============================================================================
module tb_enc_neuron_seq;

    localparam int DW  = 16;
    localparam int FB  = 8;
    localparam int NIN = 16;
    localparam int IW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          x_valid;
    logic          x_ready;
    logic [DW-1:0] x_data;
    logic [IW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] bias;
    logic          y_valid;
    logic          y_ready;
    logic [DW-1:0] y_data;

    logic [DW-1:0] wRom [NIN];
    logic [DW-1:0] xVec [NIN];
    logic [DW-1:0] sbQ [$];

    int cycle      = 0;
    int passCount  = 0;
    int checkCount = 0;
    int lastStart  = 0;
    bit prevClean  = 1'b0;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        logic [DW-1:0] b;
        logic [DW-1:0] expY;
        int            gap;
        int            yStall;
        bit            injectStart;
    } vec_t;

    vec_t vecs [5];

    enc_neuron_seq #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .N_IN       (NIN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_data  (x_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .bias    (bias),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data)
    );

    // Combinational weight ROM seen by the DUT.
    assign w_data = wRom[w_addr];

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case the DUT wedges somewhere a bounded wait cannot catch.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference neuron: plain integer arithmetic on the current ROM/inputs.
    function automatic logic [DW-1:0] modelNeuron(input logic [DW-1:0] b);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < NIN; i++) begin
            acc += longint'($signed(xVec[i])) * longint'($signed(wRom[i]));
        end
        acc += longint'($signed(b)) * 256;
        r = acc >>> FB;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (r < 0) begin
`ifdef ENC_LEAKY_RELU_EN
            r = r >>> 3;
`else
            r = 0;
`endif
        end
        return r[DW-1:0];
    endfunction

    // Runs one full evaluation. Called at #1 after a rising edge with the DUT
    // in IDLE; returns at #1 after the edge that completes the output
    // handshake, again with the DUT in IDLE.
    task automatic applyStimulus(input logic [DW-1:0] b, input logic [DW-1:0] expY,
                                 input int gap, input int yStall, input bit injectStart);
        int startCycle;
        int waitCount;
        bias = b;
        sbQ.push_back(expY);
        start = 1'b1;
        startCycle = cycle;
        if (prevClean) checkOutput("start spacing", startCycle - lastStart, NIN + 4);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy in ACC", busy, 1);

        for (int i = 0; i < NIN; i++) begin
            if (gap != 0) begin
                x_valid = 1'b0;
                @(posedge clk); #1;
                checkOutput("w_addr hold on stall", w_addr, i);
            end
            x_valid = 1'b1;
            x_data  = xVec[i];
            checkOutput("x_ready", x_ready, 1);
            checkOutput("w_addr", w_addr, i);
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        checkOutput("w_addr wrap", w_addr, 0);
        checkOutput("x_ready after last beat", x_ready, 0);

        waitCount = 0;
        while (!y_valid && waitCount < 30) begin
            @(posedge clk); #1;
            waitCount++;
        end
        checkOutput("y_valid seen", y_valid, 1);
        if (gap == 0) checkOutput("start-to-y_valid", cycle - startCycle, NIN + 3);

        for (int s = 0; s < yStall; s++) begin
            checkOutput("stall y_valid", y_valid, 1);
            checkOutput("stall y_data", y_data, sbQ[0]);
            if (injectStart && s == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        checkOutput("stall busy", busy, 1);

        y_ready = 1'b1;
        if (injectStart) start = 1'b1;
        checkOutput("y_data", y_data, sbQ.pop_front());
        @(posedge clk); #1;
        y_ready = 1'b0;
        start   = 1'b0;
        checkOutput("y_valid drop", y_valid, 0);
        checkOutput("busy back in IDLE", busy, 0);

        lastStart = startCycle;
        prevClean = (gap == 0) && (yStall == 0) && !injectStart;
    endtask

    task automatic loadUniform(input logic [DW-1:0] xv, input logic [DW-1:0] wv);
        for (int i = 0; i < NIN; i++) begin
            xVec[i] = xv;
            wRom[i] = wv;
        end
    endtask

    initial begin
        vecs[0] = '{x: 16'h0200, w: 16'h0080, b: 16'h0010, expY: 16'h1010, gap: 0, yStall: 0, injectStart: 1'b0};
`ifdef ENC_LEAKY_RELU_EN
        vecs[1] = '{x: 16'hFF00, w: 16'h0100, b: 16'h0000, expY: 16'hFE00, gap: 0, yStall: 0, injectStart: 1'b0};
        vecs[3] = '{x: 16'h8000, w: 16'h7FFF, b: 16'h0000, expY: 16'hF000, gap: 0, yStall: 0, injectStart: 1'b0};
`else
        vecs[1] = '{x: 16'hFF00, w: 16'h0100, b: 16'h0000, expY: 16'h0000, gap: 0, yStall: 0, injectStart: 1'b0};
        vecs[3] = '{x: 16'h8000, w: 16'h7FFF, b: 16'h0000, expY: 16'h0000, gap: 0, yStall: 0, injectStart: 1'b0};
`endif
        vecs[2] = '{x: 16'h7FFF, w: 16'h7FFF, b: 16'h7FFF, expY: 16'h7FFF, gap: 0, yStall: 0, injectStart: 1'b0};
        vecs[4] = '{x: 16'h0200, w: 16'h0080, b: 16'h0010, expY: 16'h1010, gap: 1, yStall: 5, injectStart: 1'b1};

        rst     = 1'b1;
        start   = 1'b0;
        x_valid = 1'b0;
        x_data  = '0;
        bias    = '0;
        y_ready = 1'b0;
        loadUniform(16'h0000, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset x_ready", x_ready, 0);
        checkOutput("reset y_valid", y_valid, 0);
        checkOutput("reset y_data", y_data, 0);
        checkOutput("reset w_addr", w_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors, run back to back.
        for (int v = 0; v < 5; v++) begin
            loadUniform(vecs[v].x, vecs[v].w);
            applyStimulus(vecs[v].b, vecs[v].expY, vecs[v].gap, vecs[v].yStall, vecs[v].injectStart);
        end

        // Reset after seven accepted beats abandons the partial sum.
        loadUniform(16'h0200, 16'h0080);
        bias  = 16'h0010;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            x_valid = 1'b1;
            x_data  = xVec[i];
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        checkOutput("w_addr before reset", w_addr, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid-reset busy", busy, 0);
        checkOutput("mid-reset x_ready", x_ready, 0);
        checkOutput("mid-reset y_valid", y_valid, 0);
        checkOutput("mid-reset w_addr", w_addr, 0);
        prevClean = 1'b0;
        applyStimulus(16'h0010, 16'h1010, 0, 0, 1'b0);

        // Random vectors against the reference model.
        for (int r = 0; r < 3; r++) begin
            logic [DW-1:0] rb;
            for (int i = 0; i < NIN; i++) begin
                xVec[i] = DW'($urandom);
                wRom[i] = DW'($urandom);
            end
            rb = DW'($urandom);
            applyStimulus(rb, modelNeuron(rb), r % 2, r, 1'b0);
        end

        checkOutput("scoreboard drained", sbQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
